message_schedule_stream: RTL and testbench
==========================================

# message_schedule_stream

Sequential SHA-256 message-schedule producer: accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input, then streams W0..W63 one word per accepted transfer to the compression round logic. Replaces the 64-entry W array with a 16-word sliding window, so expansion is computed on the fly. Sits between the block padder/loader and the round core.

## Interface
- Parameters: none; sizes come from `sha256_sched_pkg`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_word is valid
- in_ready  out  1  block accepts a word; high only in LOAD
- in_word  in  32  message word, W0 first
- out_valid  out  1  wt is valid; high only in STREAM
- out_ready  in  1  round core consumes wt
- wt  out  32  schedule word W[t]
- out_last  out  1  high with out_valid when t = 63
- out_t  out  6  current round index (only with SCHED_ROUND_IDX_EN)

## Operation
- Two states: LOAD and STREAM. Reset state is LOAD.
- **LOAD**
  - in_ready = 1. Each in_valid && in_ready writes in_word to win[load_cnt], then increments load_cnt (0..15).
  - When the word with load_cnt = 15 is accepted: go to STREAM, t = 0, load_cnt = 0.
- **STREAM**
  - out_valid = 1. A transfer occurs when out_ready = 1.
  - t < 16: wt = win[t], and a transfer only increments t.
  - t >= 16: win[j] holds W[t-16+j], and wt = win[0] + σ0(win[1]) + win[9] + σ1(win[14]) (mod 2^32). A transfer shifts the window (win[j] ← win[j+1], win[15] ← wt) and increments t.
  - σ0(x) = ror(x,7) ^ ror(x,18) ^ (x>>3); σ1(x) = ror(x,17) ^ ror(x,19) ^ (x>>10).
  - The t = 15 → 16 step does not shift, because the window already holds W0..W15.
  - Transfer at t = 63: return to LOAD, t = 0.
- **Idle values**
  - wt = 0 whenever out_valid = 0; never X.
  - out_last = 0 unless in STREAM with t = 63.
- **Backpressure:** while out_valid && !out_ready, wt, out_last, the window and t hold.
- **Input ignored outside LOAD:** in_word and in_valid are ignored in STREAM (in_ready = 0).

## Timing
- **Reset values:** in_ready = 1, out_valid = 0, wt = 0, out_last = 0, out_t = 0, state LOAD, all window words 0.
- **Load-to-stream latency:** the 16th input accept at edge N gives out_valid = 1 with wt = W0 after edge N.
- **Throughput:** one word per cycle when out_ready is held high. A block takes 16 load cycles plus 64 stream cycles.
- **No overlap:** in_ready rises in the cycle after the t = 63 transfer. There is no overlap of load and stream.
- **Output path:** wt is driven combinationally from registers only, with no path from out_ready. in_ready and out_valid are decoded from the state register.
- **Reset mid-operation:** reset_n low in any state returns to the reset values immediately. A partial block or stream is discarded.

## Configuration
- `SCHED_ROUND_IDX_EN` defined: port out_t is present and equals t while out_valid = 1, and 0 otherwise.
- Not defined: port out_t and its logic are absent; all other behaviour is identical.

## Structure
- **Package `sha256_sched_pkg`:**
  - constants BLOCK_WORDS = 16, NUM_ROUNDS = 64, WORD_W = 32
  - typedef word_t (logic [31:0])
  - state enum sched_state_e {LOAD, STREAM}
  - functions ror, sigma0, sigma1
- **Sub-module `schedule_next_word`:** the combinational four-operand sum (win[0], win[1], win[9], win[14] → next word). It is instantiated once.

## Test plan
- **"abc" block:** load W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, out_ready = 1. Required: W0..W15 are echoed, W16 = 0x61626380, W17 = 0x000F0000, and out_last is high only on the 64th word.
- **Back-to-back blocks:** after a t = 63 transfer, in_ready = 1 on the next cycle, and a second block streams its own W0 with no stale window data.
- **Backpressure:** drop out_ready for 3 cycles at t = 20. Required: wt and t are stable, and after release W20..W63 match the golden model, with no skipped or duplicated word.
- **Input gaps:** in_valid toggles 1/0 during load. Required: only the 16 accepted words are used, and out_valid rises only after the 16th.
- **Reset mid-stream:** assert reset_n = 0 at t = 40. Required: out_valid = 0, in_ready = 1, wt = 0 immediately. A fresh block then streams correctly from W0.
- **Macro coverage:** with `SCHED_ROUND_IDX_EN` defined, out_t goes 0..63 in step with transfers. The bench also compiles without the macro and passes all of the above.

Source files
------------

// File: rtl/message_schedule_stream_pkg.sv
// Shared sizes, types and SHA-256 small-sigma helpers for the message schedule.
// Optional round-index output is enabled by defining SCHED_ROUND_IDX_EN.
package sha256_sched_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int NUM_ROUNDS  = 64;
    localparam int WORD_W      = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        LOAD,
        STREAM
    } sched_state_e;

    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/message_schedule_stream_if.sv
// Load/stream handshake bundle between padder, schedule and round core.
// out_t exists only when SCHED_ROUND_IDX_EN is defined.
interface message_schedule_stream_if;
    import sha256_sched_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_word;
    logic  out_valid;
    logic  out_ready;
    word_t wt;
    logic  out_last;
`ifdef SCHED_ROUND_IDX_EN
    logic [5:0] out_t;
`endif

`ifdef SCHED_ROUND_IDX_EN
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, wt, out_last, out_t
    );
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, wt, out_last, out_t
    );
`else
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, wt, out_last
    );
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, wt, out_last
    );
`endif

endinterface

// File: rtl/schedule_next_word.sv
// Combinational expansion: W[t] from the 16-word window holding W[t-16..t-1].
// Pure sum, no state.
module schedule_next_word
    import sha256_sched_pkg::*;
(
    input  word_t i_w0,
    input  word_t i_w1,
    input  word_t i_w9,
    input  word_t i_w14,
    output word_t o_next
);

    // Four-operand modular sum of the window taps
    always_comb begin
        o_next = i_w0 + sigma0(i_w1) + i_w9 + sigma1(i_w14);
    end

endmodule

// File: rtl/message_schedule_stream.sv
// SHA-256 message schedule: loads 16 words, streams W0..W63 from a sliding window.
// Define SCHED_ROUND_IDX_EN to expose the round index on out_t.
module message_schedule_stream
    import sha256_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    message_schedule_stream_if.slave bus
);

    sched_state_e r_state;
    sched_state_e w_state_nxt;
    logic [3:0]   r_load_cnt;
    logic [5:0]   r_t;
    word_t        r_win [BLOCK_WORDS];
    word_t        w_next;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_load_done;
    logic         w_stream_done;
    logic         w_expand;

    assign w_in_fire     = bus.in_valid && (r_state == LOAD);
    assign w_out_fire    = bus.out_ready && (r_state == STREAM);
    assign w_load_done   = w_in_fire && (r_load_cnt == 4'(BLOCK_WORDS - 1));
    assign w_stream_done = w_out_fire && (r_t == 6'(NUM_ROUNDS - 1));
    // Before t=16 the window already holds W0..W15 and is only indexed
    assign w_expand      = (r_t >= 6'(BLOCK_WORDS));

    schedule_next_word u_next (
        .i_w0   (r_win[0]),
        .i_w1   (r_win[1]),
        .i_w9   (r_win[9]),
        .i_w14  (r_win[14]),
        .o_next (w_next)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave LOAD on the 16th word, leave STREAM on the 64th transfer
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LOAD:    if (w_load_done)   w_state_nxt = STREAM;
            STREAM:  if (w_stream_done) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // Outputs decoded from state and registers only; idle values are zero
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.wt        = '0;
        bus.out_last  = 1'b0;
`ifdef SCHED_ROUND_IDX_EN
        bus.out_t     = '0;
`endif
        unique case (r_state)
            LOAD: begin
                bus.in_ready = 1'b1;
            end
            STREAM: begin
                bus.out_valid = 1'b1;
                bus.wt        = w_expand ? w_next : r_win[r_t[3:0]];
                bus.out_last  = (r_t == 6'(NUM_ROUNDS - 1));
`ifdef SCHED_ROUND_IDX_EN
                bus.out_t     = r_t;
`endif
            end
            default: ;
        endcase
    end

    // Load counter and round index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_cnt <= '0;
            r_t        <= '0;
        end else begin
            if (w_in_fire) begin
                r_load_cnt <= w_load_done ? 4'd0 : r_load_cnt + 4'd1;
            end
            if (w_out_fire) begin
                r_t <= w_stream_done ? 6'd0 : r_t + 6'd1;
            end
        end
    end

    // Window: written by index while loading, shifted once expansion starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < BLOCK_WORDS; j++) begin
                r_win[j] <= '0;
            end
        end else if (w_in_fire) begin
            r_win[r_load_cnt] <= bus.in_word;
        end else if (w_out_fire && w_expand) begin
            for (int j = 0; j < BLOCK_WORDS - 1; j++) begin
                r_win[j] <= r_win[j+1];
            end
            r_win[BLOCK_WORDS-1] <= w_next;
        end
    end

endmodule

// File: tb/tb_message_schedule_stream.sv
// Self-checking bench for message_schedule_stream against a full 64-word schedule model.
// Builds with or without SCHED_ROUND_IDX_EN.
module tb_message_schedule_stream;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    message_schedule_stream_if u_if ();

    message_schedule_stream u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    bit          abc_chk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Textbook 64-entry schedule
    task automatic build_model();
        for (int i = 0; i < 64; i++) begin
            if (i < 16) exp_w[i] = blk[i];
            else exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7]
                          + ssig0(exp_w[i-15]) + exp_w[i-16];
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
    endtask

    task automatic load_block(input bit gaps);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < 16) begin
            @(negedge clk);
            chk("ld_ready", 32'(u_if.in_ready), 32'd1);
            chk("ld_ovalid", 32'(u_if.out_valid), 32'd0);
            chk("ld_wt", u_if.wt, 32'd0);
            if (gaps && cyc[0]) begin
                u_if.in_valid = 1'b0;
                u_if.in_word  = $urandom;
            end else begin
                u_if.in_valid = 1'b1;
                u_if.in_word  = blk[i];
                i++;
            end
            cyc++;
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_word  = $urandom;
    endtask

    task automatic chk_word(input int t, input string what);
        chk($sformatf("%s_wt%0d", what, t), u_if.wt, exp_w[t]);
        chk($sformatf("%s_ov%0d", what, t), 32'(u_if.out_valid), 32'd1);
        chk($sformatf("%s_last%0d", what, t), 32'(u_if.out_last),
            32'(t == 63));
`ifdef SCHED_ROUND_IDX_EN
        chk($sformatf("%s_t%0d", what, t), 32'(u_if.out_t), 32'(t));
`endif
    endtask

    task automatic chk_idle(input string what);
        chk({what, "_ready"}, 32'(u_if.in_ready), 32'd1);
        chk({what, "_ov"}, 32'(u_if.out_valid), 32'd0);
        chk({what, "_wt"}, u_if.wt, 32'd0);
        chk({what, "_last"}, 32'(u_if.out_last), 32'd0);
`ifdef SCHED_ROUND_IDX_EN
        chk({what, "_t"}, 32'(u_if.out_t), 32'd0);
`endif
    endtask

    // Called at the negedge where W0 should be presented
    task automatic stream_block(input int stall_at, input int stall_len,
                                input bit rand_bp, input int abort_at);
        int n;
        for (int t = 0; t < 64; t++) begin
            chk_word(t, "st");
            chk("st_inrdy", 32'(u_if.in_ready), 32'd0);
            if (abc_chk && t == 16) chk("abc_w16", u_if.wt, 32'h61626380);
            if (abc_chk && t == 17) chk("abc_w17", u_if.wt, 32'h000F0000);
            u_if.in_valid = (t == 63) ? 1'b0 : 1'($urandom_range(0, 1));
            u_if.in_word  = $urandom;
            if (t == abort_at) begin
                u_if.in_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                chk_idle("rst_mid");
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (t == stall_at) n = stall_len;
            else if (rand_bp && $urandom_range(0, 3) == 0) n = 1;
            else n = 0;
            if (n > 0) begin
                u_if.out_ready = 1'b0;
                repeat (n) begin
                    @(negedge clk);
                    chk_word(t, "hold");
                end
                u_if.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk_idle("post");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.in_word   = '0;
        u_if.out_ready = 1'b1;
        abc_chk        = 1'b0;
        reset_n        = 1'b0;
        #12;
        chk_idle("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle("rst_rel");

        // "abc" block
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
        abc_chk = 1'b1;
        load_block(1'b0);
        stream_block(-1, 0, 1'b0, -1);
        abc_chk = 1'b0;

        // Back-to-back block with fresh data
        rand_block();
        load_block(1'b0);
        stream_block(-1, 0, 1'b0, -1);

        // Backpressure at t=20 for 3 cycles
        rand_block();
        load_block(1'b0);
        stream_block(20, 3, 1'b0, -1);

        // Gapped input
        rand_block();
        load_block(1'b1);
        stream_block(-1, 0, 1'b0, -1);

        // Reset mid-stream then a fresh block
        rand_block();
        load_block(1'b0);
        stream_block(-1, 0, 1'b0, 40);
        chk_idle("rst_after");
        rand_block();
        load_block(1'b0);
        stream_block(-1, 0, 1'b0, -1);

        // Random mix
        for (int k = 0; k < 4; k++) begin
            rand_block();
            load_block(1'($urandom_range(0, 1)));
            stream_block(int'($urandom_range(0, 63)),
                         int'($urandom_range(1, 4)), 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
